// File: rtl/data_ram_llbit_pkg.sv
// Shared constants and link-state type for the data RAM / LL-SC responder.
package data_ram_llbit_pkg;

   localparam logic        RAM_ENABLE   = 1'b1;
   localparam logic        RAM_WRITE    = 1'b1;
   localparam logic        SET_FLAG     = 1'b1;
   localparam logic        CLEAR_FLAG   = 1'b0;
   localparam logic        VALID        = 1'b1;
   localparam logic [31:0] ZERO         = 32'h0000_0000;
   localparam logic        RST_ENABLE_N = 1'b0;

   typedef enum logic {
      LINK_CLEAR = 1'b0,
      LINK_SET   = 1'b1
   } link_e;

endpackage

// File: rtl/data_ram_llbit_if.sv
// MEM-stage access port plus snoop port of the data RAM responder.
interface data_ram_llbit_if;
   logic        memCe;
   logic        memWr;
   logic [31:0] memAddr;
   logic [31:0] wtData;
   logic [31:0] rdData;
   logic        wbit;
   logic        wLLbit;
   logic        flush;
   logic        snpWr;
   logic [31:0] snpAddr;
   logic        rLLbit;
   logic        alignErr;

   modport master (
      output memCe, memWr, memAddr, wtData, wbit, wLLbit, flush, snpWr, snpAddr,
      input  rdData, rLLbit, alignErr
   );

   modport slave (
      input  memCe, memWr, memAddr, wtData, wbit, wLLbit, flush, snpWr, snpAddr,
      output rdData, rLLbit, alignErr
   );
endinterface

// File: rtl/data_ram_llbit_llbit_reg.sv
// LL/SC link state: LLbit plus the linked word address, with a fixed update priority.
//
//   state      | meaning
//   LINK_CLEAR | no reservation held; only flush or an Ll can act
//   LINK_SET   | reservation on link_addr; stores/snoops to that word break it
module llbit_reg
   import data_ram_llbit_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        wbit,
   input  logic        wLLbit,
   input  logic        st_en,
   input  logic [29:0] acc_word,
   input  logic        snp_wr,
   input  logic [29:0] snp_word,
   output logic        rLLbit
);

   link_e       state, state_nxt;
   logic [29:0] link_addr, link_addr_nxt;
   logic        ll_req, sc_req;

   assign ll_req = (wbit == VALID) && (wLLbit == SET_FLAG);
   assign sc_req = (wbit == VALID) && (wLLbit == CLEAR_FLAG);

   always_ff @(posedge clk or negedge rst) begin
      if (rst == RST_ENABLE_N) begin
         state     <= LINK_CLEAR;
         link_addr <= '0;
      end else begin
         state     <= state_nxt;
         link_addr <= link_addr_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      link_addr_nxt = link_addr;
      if (flush) begin
         state_nxt = LINK_CLEAR;
      end else if (ll_req) begin
         // An Ll outranks a same-cycle snoop hit, so the new link survives.
         state_nxt     = LINK_SET;
         link_addr_nxt = acc_word;
      end else if (sc_req) begin
         state_nxt = LINK_CLEAR;
      end else begin
         case (state)
            LINK_SET: begin
               if ((st_en && acc_word == link_addr) || (snp_wr && snp_word == link_addr))
                  state_nxt = LINK_CLEAR;
            end
            default: state_nxt = state;
         endcase
      end
   end

   assign rLLbit = (state == LINK_SET) ? SET_FLAG : CLEAR_FLAG;

endmodule

// File: rtl/data_ram_llbit.sv
// Data RAM responder: async word read, clocked write, and LL/SC link tracking.
module data_ram_llbit
   import data_ram_llbit_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic            clk,
   input  logic            rst,
   data_ram_llbit_if.slave bus
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [31:0]       mem [DEPTH];
   logic [ADDR_W-1:0] idx;
   logic              in_range, aligned, rd_hit, wr_hit, st_en;

   assign idx      = bus.memAddr[ADDR_W+1:2];
   assign in_range = (bus.memAddr[31:ADDR_W+2] == '0);
   assign aligned  = (bus.memAddr[1:0] == 2'b00);
   assign st_en    = (bus.memCe == RAM_ENABLE) && (bus.memWr == RAM_WRITE);
   assign rd_hit   = (bus.memCe == RAM_ENABLE) && (bus.memWr != RAM_WRITE) && in_range && aligned;
   assign wr_hit   = st_en && in_range && aligned;

   assign bus.alignErr = (bus.memCe == RAM_ENABLE) && !aligned;
   assign bus.rdData   = (rst != RST_ENABLE_N && rd_hit) ? mem[idx] : ZERO;

   // The array is never reset; a write pending while rst is low is simply dropped.
   always_ff @(posedge clk) begin
      if (rst != RST_ENABLE_N && wr_hit)
         mem[idx] <= bus.wtData;
   end

   llbit_reg u_llbit (
      .clk      (clk),
      .rst      (rst),
      .flush    (bus.flush),
      .wbit     (bus.wbit),
      .wLLbit   (bus.wLLbit),
      .st_en    (st_en),
      .acc_word (bus.memAddr[31:2]),
      .snp_wr   (bus.snpWr),
      .snp_word (bus.snpAddr[31:2]),
      .rLLbit   (bus.rLLbit)
   );

endmodule
